uart_rx: RTL

//  Standalone UART receiver: the receive side of the 8N1/8E1/8O1 UART serial link, paired with the existing transmitter.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings, synchronizer
// depth, default oversampling ratio and a width helper for counters.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;
    localparam int DEFAULT_CLOCKS_PER_BIT     = 8;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int counter_width(input int range_value);
        return (range_value > 1) ? $clog2(range_value) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for the asynchronous serial line. Resets to 1 so the
// receiver sees an idle (high) line while and right after reset.
module uart_rx_sync
    import uart_rx_pkg::*;
#(
    parameter int STAGES = NUMBER_OF_RX_SYNCHRONIZERS
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw line through the flop chain; idle level on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1/8E1/8O1 style): synchronizes serial_in, finds the start
// edge, samples every bit in its middle and reports one byte per frame with
// parity and framing status as single-cycle pulses.
// Optional feature macro: UART_RX_BREAK_DETECT_EN adds the break_detect output
// and a BREAK state that waits for the line to return high.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        framing_error,
    output logic                        rx_busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                        break_detect
`endif
);

    localparam int TW = counter_width(CLOCKS_PER_BIT);
    localparam int BW = counter_width(INPUT_DATA_WIDTH);

    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(INPUT_DATA_WIDTH - 1);
    localparam logic PARITY_ON  = (PARITY_ENABLED != 0) ? 1'b1 : 1'b0;
    localparam logic PARITY_ODD = (PARITY_TYPE != 0) ? 1'b1 : 1'b0;

    // High when the received parity bit disagrees with the configured parity.
    function automatic logic parity_mismatch(input logic [INPUT_DATA_WIDTH-1:0] data,
                                             input logic parity_bit);
        return parity_bit ^ (^data) ^ PARITY_ODD;
    endfunction

    logic                        rxd_s;
    rx_state_e                   state_r, state_s;
    logic [TW-1:0]               tick_r, tick_s;
    logic [BW-1:0]               bit_idx_r, bit_idx_s;
    logic [INPUT_DATA_WIDTH-1:0] shift_r, shift_s;
    logic                        perr_r, perr_s;
    logic [INPUT_DATA_WIDTH-1:0] data_r, data_s;
    logic                        valid_r, valid_s;
    logic                        rxerr_r, rxerr_s;
    logic                        ferr_r, ferr_s;
    logic                        busy_r, busy_s;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                        par_bit_r, par_bit_s;
    logic                        brk_r, brk_s;
`endif

    uart_rx_sync #(
        .STAGES(NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (serial_in),
        .q    (rxd_s)
    );

    // Next-state, datapath and output-pulse decisions for the receive FSM.
    always_comb begin
        state_s   = state_r;
        tick_s    = tick_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        perr_s    = perr_r;
        data_s    = data_r;
        valid_s   = 1'b0;
        rxerr_s   = 1'b0;
        ferr_s    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_s = par_bit_r;
        brk_s     = 1'b0;
`endif
        case (state_r)
            RX_IDLE: begin
                if (rxd_s == 1'b0) begin
                    state_s = RX_START;
                    tick_s  = TICK_ZERO;
                    perr_s  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_s = 1'b0;
`endif
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick_r == TICK_MID) begin
                    tick_s = TICK_ZERO;
                    if (rxd_s == 1'b1) begin
                        // Line went back high before mid-start: glitch.
                        state_s = RX_IDLE;
                    end else begin
                        state_s   = RX_DATA;
                        bit_idx_s = BIT_ZERO;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            RX_DATA: begin
                if (tick_r == TICK_END) begin
                    tick_s  = TICK_ZERO;
                    shift_s = {rxd_s, shift_r[INPUT_DATA_WIDTH-1:1]};
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_s = BIT_ZERO;
                        state_s   = PARITY_ON ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + BIT_ONE;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            RX_PARITY: begin
                if (tick_r == TICK_END) begin
                    tick_s  = TICK_ZERO;
                    perr_s  = parity_mismatch(shift_r, rxd_s);
                    state_s = RX_STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_s = rxd_s;
`endif
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            RX_STOP: begin
                if (tick_r == TICK_END) begin
                    tick_s = TICK_ZERO;
                    if (rxd_s == 1'b1) begin
                        valid_s = 1'b1;
                        rxerr_s = perr_r;
                        data_s  = shift_r;
                        state_s = RX_IDLE;
                    end else begin
`ifdef UART_RX_BREAK_DETECT_EN
                        if ((shift_r == {INPUT_DATA_WIDTH{1'b0}}) && (par_bit_r == 1'b0)) begin
                            brk_s   = 1'b1;
                            state_s = RX_BREAK;
                        end else begin
                            ferr_s  = 1'b1;
                            state_s = RX_IDLE;
                        end
`else
                        ferr_s  = 1'b1;
                        state_s = RX_IDLE;
`endif
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            RX_BREAK: begin
                if (rxd_s == 1'b1) begin
                    state_s = RX_IDLE;
                end else begin
                    state_s = RX_BREAK;
                end
            end
`endif
            default: begin
                state_s   = RX_IDLE;
                tick_s    = TICK_ZERO;
                bit_idx_s = BIT_ZERO;
            end
        endcase
        busy_s = (state_s != RX_IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= RX_IDLE;
            tick_r    <= TICK_ZERO;
            bit_idx_r <= BIT_ZERO;
            shift_r   <= {INPUT_DATA_WIDTH{1'b0}};
            perr_r    <= 1'b0;
            data_r    <= {INPUT_DATA_WIDTH{1'b0}};
            valid_r   <= 1'b0;
            rxerr_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_r <= 1'b0;
            brk_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            tick_r    <= tick_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            perr_r    <= perr_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            rxerr_r   <= rxerr_s;
            ferr_r    <= ferr_s;
            busy_r    <= busy_s;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_r <= par_bit_s;
            brk_r     <= brk_s;
`endif
        end
    end

    assign received_data = data_r;
    assign data_is_valid = valid_r;
    assign rx_error      = rxerr_r;
    assign framing_error = ferr_r;
    assign rx_busy       = busy_r;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_detect  = brk_r;
`endif

endmodule
